// File: rtl/lebug_pkg.sv
// rtl/lebug_pkg.sv - shared config ids, state/mode types and helpers for the trace buffer
package lebug_pkg;

  // configId value the trace buffer answers to on the shared config bus
  localparam logic [7:0] TRACE_BUFFER_CONFIG_ID = 8'd1;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    EMPTY   = 2'd2
  } tb_state_t;

  typedef enum logic {
    MODE_CIRCULAR = 1'b0,
    MODE_STOP     = 1'b1
  } tb_mode_t;

  // Saturating byte counter step: sticks at 255 so long config streams never wrap
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port vector store with a registered read port
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 256
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port plus one-cycle registered read; contents are not reset
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - circular capture buffer draining oldest-first over valid/ready
module trace_buffer
  import lebug_pkg::*;
#(
  parameter int         N                  = 8,
  parameter int         DATA_WIDTH         = 32,
  parameter int         DEPTH              = 64,
  parameter logic [7:0] PERSONAL_CONFIG_ID = TRACE_BUFFER_CONFIG_ID,
  parameter int         INITIAL_MODE       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tracing,
  input  logic                          valid_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]  vector_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic                          ready_in,
  output logic [N-1:0][DATA_WIDTH-1:0]  vector_out,
  output logic                          valid_out,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int VW = N * DATA_WIDTH;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam tb_mode_t RESET_MODE = (INITIAL_MODE != 0) ? MODE_STOP : MODE_CIRCULAR;

  tb_state_t state_q, state_d;
  tb_mode_t  mode_q, mode_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic          valid_q, valid_d;
  logic          fresh_q, fresh_d;
  logic [VW-1:0] hold_q, hold_d;
  logic [VW-1:0] rd_data;

  logic full, cap, wr_en, issue, abort, cfg_active;
  logic cfg_unused;

  // Only bit 0 of the config byte is meaningful to this block
  assign cfg_unused = ^configData[7:1];

  assign full       = (count_q == FULL_COUNT);
  assign cap        = tracing && valid_in;
  assign wr_en      = cap && (!full || mode_q == MODE_CIRCULAR);
  assign abort      = (state_q == DRAIN) && tracing;
  assign issue      = (state_q == DRAIN) && !tracing && (count_q != '0) && (!valid_q || ready_in);
  assign cfg_active = !tracing && (state_q != DRAIN);

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (VW)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (vector_in),
    .rd_en_i   (issue),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // Fresh RAM data goes straight out; afterwards the holding copy keeps it stable
  assign vector_out = fresh_q ? rd_data : hold_q;
  assign valid_out  = valid_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

  // Capture/drain/empty sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAPTURE: if (!tracing) state_d = DRAIN;
      DRAIN: begin
        if (tracing) state_d = CAPTURE;
        else if (count_q == '0 && !valid_q) state_d = EMPTY;
      end
      EMPTY:   if (tracing) state_d = CAPTURE;
      default: state_d = CAPTURE;
    endcase
  end

  // Pointer, occupancy, overflow and config decode; capture, drain and config never coincide
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mode_d     = mode_q;
    byte_cnt_d = byte_cnt_q;

    if (cap) begin
      if (!full) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + CW'(1);
      end else if (mode_q == MODE_CIRCULAR) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        rd_ptr_d   = rd_ptr_q + AW'(1);
        overflow_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (issue) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q - CW'(1);
    end

    if (cfg_active) begin
      if (configId == PERSONAL_CONFIG_ID) begin
        byte_cnt_d = sat_inc8(byte_cnt_q);
        if (byte_cnt_q == 8'd0) begin
          mode_d = tb_mode_t'(configData[0]);
        end else if (byte_cnt_q == 8'd1) begin
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end else begin
        byte_cnt_d = 8'd0;
      end
    end
  end

  // Output slot: fills on issue, empties on accept, dropped outright when tracing resumes
  always_comb begin
    valid_d = valid_q;
    fresh_d = issue;
    hold_d  = fresh_q ? rd_data : hold_q;
    if (abort || state_q != DRAIN) valid_d = 1'b0;
    else if (issue)                 valid_d = 1'b1;
    else if (ready_in)              valid_d = 1'b0;
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CAPTURE;
      mode_q     <= RESET_MODE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      byte_cnt_q <= 8'd0;
      valid_q    <= 1'b0;
      fresh_q    <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      byte_cnt_q <= byte_cnt_d;
      valid_q    <= valid_d;
      fresh_q    <= fresh_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - randomized self-checking bench for trace_buffer
module tb_trace_buffer;
  localparam int N     = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst, tracing, valid_in, ready_in;
  vec_t vector_in, vector_out;
  logic [7:0] configId, configData;
  logic valid_out, overflow;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  vec_t model_q[$];
  bit   model_ovf;
  bit   model_stop;
  vec_t got_q[$];
  int   acc_cyc[$];
  bit   timed_out;

  always #5 clk = ~clk;

  trace_buffer #(
    .N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .PERSONAL_CONFIG_ID(8'd1), .INITIAL_MODE(0)
  ) dut (
    .clk(clk), .rst(rst), .tracing(tracing), .valid_in(valid_in), .vector_in(vector_in),
    .configId(configId), .configData(configData), .ready_in(ready_in),
    .vector_out(vector_out), .valid_out(valid_out), .count(count), .overflow(overflow)
  );

  function automatic vec_t mk_vec(input int lane0);
    vec_t v;
    for (int l = 0; l < N; l++) v[l] = $urandom;
    v[0] = lane0;
    return v;
  endfunction

  // Reference: a bounded FIFO of what the host should eventually see
  task automatic model_write(input vec_t v);
    if (model_q.size() < DEPTH) model_q.push_back(v);
    else if (!model_stop) begin
      void'(model_q.pop_front());
      model_q.push_back(v);
      model_ovf = 1'b1;
    end else model_ovf = 1'b1;
  endtask

  task automatic capture(input int n, input int base, input bit gaps);
    int i = 0;
    tracing = 1'b1;
    while (i < n) begin
      if (gaps && $urandom_range(0, 3) == 0) valid_in = 1'b0;
      else begin
        valid_in  = 1'b1;
        vector_in = mk_vec(base + i);
        model_write(vector_in);
        i++;
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic configure(input bit stop);
    tracing = 1'b0;
    configId = 8'd1; configData = {7'($urandom), stop};
    @(posedge clk); #1;
    configData = $urandom;
    @(posedge clk); #1;
    configId = 8'd0; configData = 8'd0;
    @(posedge clk); #1;
    model_stop = stop;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic drain_collect(input int expect_n, input int ready_pct);
    int cyc = 0;
    int idle = 0;
    got_q.delete(); acc_cyc.delete(); timed_out = 1'b0;
    tracing = 1'b0; valid_in = 1'b0;
    while (idle < 6) begin
      ready_in = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if (valid_out && ready_in) begin
        got_q.push_back(vector_out);
        acc_cyc.push_back(cyc);
      end
      if (got_q.size() >= expect_n && !valid_out) idle++;
      cyc++;
      @(posedge clk); #1;
      if (cyc > 3000) begin timed_out = 1'b1; break; end
    end
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tracing = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    vector_in = '0; configId = 8'd0; configData = 8'd0;
    model_q.delete(); model_ovf = 1'b0; model_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (vector_out !== '0) begin errors++; $display("FAIL reset_vector got %h exp 0", vector_out); end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_basic();
    capture(10, 0, 1'b0);
    drain_collect(model_q.size(), 100);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL basic_len got %0d exp 10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
      checks++;
      if (got_q[i] !== model_q[i] || got_q[i][0] !== DW'(i)) begin
        errors++; $display("FAIL basic_data[%0d] got %h exp %h", i, got_q[i], model_q[i]);
      end
    end
    if (acc_cyc.size() == 10) begin
      checks++;
      if (acc_cyc[9] - acc_cyc[0] != 9) begin
        errors++; $display("FAIL basic_back_to_back got span %0d exp 9", acc_cyc[9] - acc_cyc[0]);
      end
    end
    model_q.delete();
    checks++; if (count !== '0) begin errors++; $display("FAIL basic_count got %0d exp 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow got %b exp 0", overflow); end
  endtask

  task automatic test_wrap(input bit stop);
    configure(stop);
    checks++; if (overflow !== 1'b0 || count !== '0) begin
      errors++; $display("FAIL wrap_clear got ovf %b count %0d exp 0 0", overflow, count);
    end
    capture(70, 0, 1'b0);
    @(negedge clk);
    checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL wrap_full_count got %0d exp %0d", count, DEPTH); end
    @(posedge clk); #1;
    drain_collect(model_q.size(), 100);
    checks++; if (got_q.size() != 64 || timed_out) begin errors++; $display("FAIL wrap_len got %0d exp 64", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
      checks++;
      if (got_q[i] !== model_q[i] || got_q[i][0] !== DW'(stop ? i : i + 6)) begin
        errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, got_q[i], model_q[i]);
      end
    end
    model_q.delete();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wrap_overflow got %b exp 1", overflow); end
  endtask

  task automatic test_stall();
    vec_t held;
    int cyc = 0;
    configure(1'b0);
    capture(5, 20, 1'b0);
    tracing = 1'b0; ready_in = 1'b0;
    @(negedge clk);
    while (!valid_out && cyc < 50) begin @(posedge clk); #1; @(negedge clk); cyc++; end
    checks++; if (!valid_out) begin errors++; $display("FAIL stall_first_valid got 0 exp 1"); end
    held = vector_out;
    checks++; if (held !== model_q[0]) begin errors++; $display("FAIL stall_first_data got %h exp %h", held, model_q[0]); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; @(negedge clk);
      checks++;
      if (valid_out !== 1'b1 || vector_out !== held) begin
        errors++; $display("FAIL stall_hold[%0d] got %b/%h exp 1/%h", k, valid_out, vector_out, held);
      end
    end
    @(posedge clk); #1;
    drain_collect(model_q.size(), 100);
    checks++; if (got_q.size() != 5 || timed_out) begin errors++; $display("FAIL stall_len got %0d exp 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
      checks++;
      if (got_q[i] !== model_q[i]) begin errors++; $display("FAIL stall_data[%0d] got %h exp %h", i, got_q[i], model_q[i]); end
    end
    model_q.delete();
  endtask

  task automatic test_abort();
    int acc = 0;
    int cyc = 0;
    vec_t exp_v;
    configure(1'b0);
    capture(5, 0, 1'b0);
    tracing = 1'b0; ready_in = 1'b1;
    while (acc < 2 && cyc < 100) begin
      @(negedge clk);
      if (valid_out && ready_in) begin
        exp_v = model_q.pop_front();
        checks++;
        if (vector_out !== exp_v) begin errors++; $display("FAIL abort_pre[%0d] got %h exp %h", acc, vector_out, exp_v); end
        acc++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++; if (acc != 2) begin errors++; $display("FAIL abort_wait got %0d exp 2", acc); end
    // The vector sitting unaccepted on the output when tracing returns is discarded
    if (model_q.size() > 0) void'(model_q.pop_front());
    tracing = 1'b1; ready_in = 1'b0; valid_in = 1'b1; vector_in = mk_vec(99);
    model_write(vector_in);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", valid_out); end
    checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL abort_count got %0d exp %0d", count, model_q.size()); end
    @(posedge clk); #1;
    drain_collect(model_q.size(), 100);
    checks++; if (got_q.size() != 3 || timed_out) begin errors++; $display("FAIL abort_len got %0d exp 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
      checks++;
      if (got_q[i] !== model_q[i]) begin errors++; $display("FAIL abort_data[%0d] got %h exp %h", i, got_q[i], model_q[i]); end
    end
    if (got_q.size() == 3) begin
      checks++;
      if (got_q[0][0] !== 32'd3 || got_q[1][0] !== 32'd4 || got_q[2][0] !== 32'd99) begin
        errors++; $display("FAIL abort_order got %0d,%0d,%0d exp 3,4,99", got_q[0][0], got_q[1][0], got_q[2][0]);
      end
    end
    model_q.delete();
  endtask

  task automatic test_random();
    int n, pct;
    bit stop;
    for (int r = 0; r < 5; r++) begin
      stop = $urandom_range(0, 1);
      configure(stop);
      n = $urandom_range(1, 100);
      capture(n, 1000 * r, 1'b1);
      @(negedge clk);
      checks++; if (count !== CW'(model_q.size())) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", r, count, model_q.size()); end
      @(posedge clk); #1;
      pct = $urandom_range(30, 100);
      drain_collect(model_q.size(), pct);
      checks++; if (got_q.size() != model_q.size() || timed_out) begin
        errors++; $display("FAIL rand%0d_len got %0d exp %0d", r, got_q.size(), model_q.size());
      end
      for (int i = 0; i < got_q.size() && i < model_q.size(); i++) begin
        checks++;
        if (got_q[i] !== model_q[i]) begin errors++; $display("FAIL rand%0d_data[%0d] got %h exp %h", r, i, got_q[i], model_q[i]); end
      end
      checks++; if (overflow !== model_ovf) begin errors++; $display("FAIL rand%0d_overflow got %b exp %b", r, overflow, model_ovf); end
      model_q.delete();
    end
  endtask

  task automatic test_reset_mid_drain();
    int cyc = 0;
    configure(1'b1);
    capture(70, 0, 1'b0);
    tracing = 1'b0; ready_in = 1'b0;
    @(negedge clk);
    while (!valid_out && cyc < 50) begin @(posedge clk); #1; @(negedge clk); cyc++; end
    checks++; if (!valid_out || !overflow) begin errors++; $display("FAIL rstmid_setup got valid %b ovf %b exp 1 1", valid_out, overflow); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (valid_out !== 1'b0 || count !== '0 || overflow !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear got valid %b count %0d ovf %b exp 0 0 0", valid_out, count, overflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete(); model_ovf = 1'b0; model_stop = 1'b0;
    drain_collect(0, 100);
    checks++; if (got_q.size() != 0 || timed_out) begin errors++; $display("FAIL rstmid_drain got %0d exp 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap(1'b0);
    test_wrap(1'b1);
    test_stall();
    test_abort();
    test_random();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
